// File: rtl/spi_adc_responder.sv
// spi_adc_responder
//   SPI mode-0 responder that stands in for an ADC. Samples queued on a
//   valid/ready port are held in a small FIFO. They are sent MSB-first on miso,
//   one word per cs_n frame. cs_n and sck are oversampled on clk; they are
//   never used as clocks.
//
//   Optional feature macro: SPI_RESP_PARITY_EN
//     When defined, each frame carries one extra bit after the data LSB.
//     That bit makes the sent word even parity.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   sample_data  parallel sample to queue
//   sample_valid sample_data is valid
//   sample_ready FIFO not full (registered); push = sample_valid & sample_ready
//   cs_n, sck    SPI select and clock from the master (asynchronous inputs)
//   miso         serial data to the master
//   miso_oe      high while a frame is selected (pad tristate control)
//   frame_done   1-cycle pulse: all frame bits delivered
//   frame_abort  1-cycle pulse: cs_n released before frame_done
//   underrun     1-cycle pulse: frame started with the FIFO empty
//   fifo_level   number of entries held
module spi_adc_responder #(
  parameter int unsigned          DATA_W     = 16,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0]    IDLE_WORD  = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               sample_data,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  input  logic                            cs_n,
  input  logic                            sck,
  output logic                            miso,
  output logic                            miso_oe,
  output logic                            frame_done,
  output logic                            frame_abort,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
`ifdef SPI_RESP_PARITY_EN
  localparam int unsigned FRAME_W = DATA_W + 1;
`else
  localparam int unsigned FRAME_W = DATA_W;
`endif
  localparam int unsigned CW = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t state, state_next;

  // Two synchronizer flops, then one edge-detect flop, per SPI input.
  logic cs_s1, cs_s2, cs_d;
  logic sck_s1, sck_s2, sck_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_d   <= 1'b1;
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
    end else begin
      cs_s1  <= cs_n;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall;
  assign cs_fall  =  cs_d  & ~cs_s2;
  assign cs_rise  = ~cs_d  &  cs_s2;
  assign sck_rise = ~sck_d &  sck_s2;
  assign sck_fall =  sck_d & ~sck_s2;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_next;
  logic              push, pop, fifo_empty;

  logic [DATA_W-1:0] shreg, last_word;
  logic [CW-1:0]     bit_cnt;
`ifdef SPI_RESP_PARITY_EN
  logic              par_bit;
`endif

  logic do_load, do_shift, cnt_inc, frame_end, abort;

  assign fifo_empty = (fifo_level == '0);
  assign push       = sample_valid & sample_ready;
  assign pop        = do_load & ~fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    cnt_inc    = 1'b0;
    frame_end  = 1'b0;
    abort      = 1'b0;
    miso       = 1'b0;
    miso_oe    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cs_fall) state_next = S_LOAD;
      end
      S_LOAD: begin
        do_load    = 1'b1;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        miso_oe = 1'b1;
        miso    = shreg[DATA_W-1];
`ifdef SPI_RESP_PARITY_EN
        // Once every data bit has been sampled, the parity bit drives the line.
        if (bit_cnt == CW'(DATA_W)) miso = par_bit;
`endif
        if (cs_rise) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else begin
          if (sck_rise) begin
            cnt_inc = 1'b1;
            if (bit_cnt == CW'(FRAME_W - 1)) begin
              frame_end  = 1'b1;
              state_next = S_DONE;
            end
          end
          if (sck_fall) do_shift = 1'b1;
        end
      end
      S_DONE: begin
        miso_oe = 1'b1;
        if (cs_rise) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    level_next = fifo_level;
    unique case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  // The storage array has no reset; the pointers and the level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      sample_ready <= 1'b1;
      shreg        <= '0;
      last_word    <= IDLE_WORD;
      bit_cnt      <= '0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      underrun     <= 1'b0;
`ifdef SPI_RESP_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      fifo_level   <= level_next;
      // ready follows the next level, so a pop does not free a slot until the following cycle
      sample_ready <= (level_next != LW'(FIFO_DEPTH));
      frame_done   <= frame_end;
      frame_abort  <= abort;
      underrun     <= do_load & fifo_empty;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (do_load) begin
        bit_cnt <= '0;
        if (pop) begin
          shreg     <= mem[rd_ptr];
          last_word <= mem[rd_ptr];
`ifdef SPI_RESP_PARITY_EN
          par_bit   <= ^mem[rd_ptr];
`endif
        end else begin
          shreg     <= last_word;
`ifdef SPI_RESP_PARITY_EN
          par_bit   <= ^last_word;
`endif
        end
      end else begin
        if (cnt_inc)  bit_cnt <= bit_cnt + CW'(1);
        if (do_shift) shreg   <= {shreg[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
module tb_spi_adc_responder;

  localparam int DATA_W = 16;
`ifdef SPI_RESP_PARITY_EN
  localparam int FRAME_W = 17;
`else
  localparam int FRAME_W = 16;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              cs_n = 1'b1;
  logic              sck = 1'b0;
  logic              miso, miso_oe, frame_done, frame_abort, underrun;
  logic [2:0]        fifo_level;

  spi_adc_responder #(.DATA_W(16), .FIFO_DEPTH(4), .IDLE_WORD(16'h0000)) dut (
    .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .cs_n(cs_n), .sck(sck), .miso(miso), .miso_oe(miso_oe),
    .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_abort  = 0;
  int n_under  = 0;

  always @(posedge clk) begin
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (underrun)    n_under++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    ticks(1);
    sample_valid = 1'b0;
  endtask

  // Mode-0 master: sample miso just before each rising sck, 4 clk per phase.
  task automatic run_frame(input int rises, output logic [DATA_W-1:0] word, output logic par);
    logic [DATA_W:0] acc;
    acc  = '0;
    cs_n = 1'b0;
    ticks(6);
    check("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
    for (int i = 0; i < rises; i++) begin
      acc = {acc[DATA_W-1:0], miso};
      sck = 1'b1;
      ticks(4);
      sck = 1'b0;
      ticks(4);
    end
    cs_n = 1'b1;
    ticks(6);
    if (rises == DATA_W + 1) begin
      word = acc[DATA_W:1];
      par  = acc[0];
    end else begin
      word = acc[DATA_W-1:0];
      par  = 1'b0;
    end
  endtask

  task automatic frame_check(input string tag, input logic [DATA_W-1:0] exp_word,
                             input int exp_under, input logic exp_par);
    logic [DATA_W-1:0] w;
    logic              p;
    int d0, a0, u0;
    d0 = n_done; a0 = n_abort; u0 = n_under;
    run_frame(FRAME_W, w, p);
    check({tag, "_word"},     {16'd0, w},                exp_word);
    check({tag, "_done"},     n_done - d0,               32'd1);
    check({tag, "_abort"},    n_abort - a0,              32'd0);
    check({tag, "_underrun"}, n_under - u0,              exp_under);
`ifdef SPI_RESP_PARITY_EN
    check({tag, "_parity"},   {31'd0, p},                {31'd0, exp_par});
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic              p;
    int d0, a0;

    ticks(3);
    check("rst_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_miso",  {31'd0, miso},         32'd0);
    check("rst_oe",    {31'd0, miso_oe},      32'd0);
    check("rst_level", {29'd0, fifo_level},   32'd0);
    check("rst_pulses", {29'd0, frame_done, frame_abort, underrun}, 32'd0);
    reset = 1'b1;
    ticks(2);

    // Empty FIFO before anything was sent: IDLE_WORD plus underrun.
    frame_check("idle", 16'h0000, 1, 1'b0);

    // One word, two frames: second frame repeats it with underrun.
    push(16'h1234);
    check("lvl_1234", {29'd0, fifo_level}, 32'd1);
    frame_check("f1234a", 16'h1234, 0, 1'b1);
    frame_check("f1234b", 16'h1234, 1, 1'b1);

    push(16'hA5C3);
    check("lvl_a5c3_pre", {29'd0, fifo_level}, 32'd1);
    frame_check("a5c3", 16'hA5C3, 0, 1'b0);
    check("lvl_a5c3_post", {29'd0, fifo_level}, 32'd0);

    // Fill to depth.
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    check("ready_lvl3", {31'd0, sample_ready}, 32'd1);
    push(16'h0004);
    check("ready_full", {31'd0, sample_ready}, 32'd0);
    check("lvl_full",   {29'd0, fifo_level},   32'd4);
    frame_check("q1", 16'h0001, 0, 1'b1);
    check("ready_after_pop", {31'd0, sample_ready}, 32'd1);
    frame_check("q2", 16'h0002, 0, 1'b1);
    frame_check("q3", 16'h0003, 0, 1'b0);
    frame_check("q4", 16'h0004, 0, 1'b1);
    check("lvl_drained", {29'd0, fifo_level}, 32'd0);

    // Abort after 5 rises of FFFF; FFFF is dropped and 5555 follows.
    push(16'hFFFF);
    push(16'h5555);
    d0 = n_done; a0 = n_abort;
    run_frame(5, w, p);
    check("abort_bits",  {27'd0, w[4:0]}, 32'h1F);
    check("abort_pulse", n_abort - a0,    32'd1);
    check("abort_done",  n_done - d0,     32'd0);
    check("abort_lvl",   {29'd0, fifo_level}, 32'd1);
    frame_check("after_abort", 16'h5555, 0, 1'b0);

    // Reset asserted at rise 8 of a frame.
    push(16'hABCD);
    push(16'h1357);
    cs_n = 1'b0;
    ticks(6);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b1;
      ticks(4);
      if (i < 7) begin
        sck = 1'b0;
        ticks(4);
      end
    end
    reset = 1'b0;
    #1;
    check("midrst_miso",  {31'd0, miso},         32'd0);
    check("midrst_oe",    {31'd0, miso_oe},      32'd0);
    check("midrst_level", {29'd0, fifo_level},   32'd0);
    check("midrst_ready", {31'd0, sample_ready}, 32'd1);
    sck  = 1'b0;
    cs_n = 1'b1;
    ticks(3);
    reset = 1'b1;
    ticks(3);
    // Flushed FIFO and last word back to IDLE_WORD.
    frame_check("post_reset", 16'h0000, 1, 1'b0);

`ifdef SPI_RESP_PARITY_EN
    push(16'h0007);
    push(16'h0003);
    frame_check("par7", 16'h0007, 0, 1'b1);
    frame_check("par3", 16'h0003, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
